sfm_tcdm_responder: RTL
=======================

Name: sfm_tcdm_responder

Overview:
- Multi-port TCDM slave memory: the responder end of the MP-lane TCDM master interface that the softmax accelerator wrapper drives.
- Used in block-level testbenches and emulation builds in place of the cluster TCDM.
- Each lane performs the req/gnt handshake, a fixed-latency read/write into a shared word array, and returns in-order responses that honour r_ready backpressure.
- Supports deterministic grant stalling for verification.

Parameters:
- MP, 4, number of independent 32-bit TCDM lanes.
- MEM_WORDS, 4096, depth of the shared 32-bit word array; power of two.
- LAT, 2, grant-to-earliest-response latency in cycles; must be ≥1.
- FIFO_DEPTH, 4, maximum outstanding transactions per lane, counting pipeline entries plus queued responses; must be ≥1.
- IW, 8, transaction ID width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- tcdm_req_i  in  [MP]  request per lane.
- tcdm_gnt_o  out  [MP]  grant per lane.
- tcdm_add_i  in  [MP][32]  byte address.
- tcdm_wen_i  in  [MP]  1 = read, 0 = write.
- tcdm_be_i  in  [MP][4]  byte enables (writes only).
- tcdm_data_i  in  [MP][32]  write data.
- tcdm_id_i  in  [MP][IW]  transaction ID.
- tcdm_r_ready_i  in  [MP]  master accepts response.
- tcdm_r_valid_o  out  [MP]  response valid.
- tcdm_r_data_o  out  [MP][32]  read data; 0 for write responses.
- tcdm_r_id_o  out  [MP][IW]  ID of the returned transaction.
- stall_i  in  [MP]  force gnt low on the lane (test throttle).
- busy_o  out  1  any lane has outstanding transactions.

Behaviour:
- Reset (rst_i = 1 at a clock edge):
  - clears all pipelines, FIFOs and outstanding counters.
  - Memory contents are NOT cleared.
  - While rst_i is high: gnt_o = 0, r_valid_o = 0, r_data_o = 0, r_id_o = 0, busy_o = 0.
  - Reset mid-operation discards all in-flight responses silently.
- Addressing:
  - word index = add[AW+1:2], where AW = log2(MEM_WORDS).
  - Upper bits are ignored, so addresses wrap modulo MEM_WORDS*4.
  - add[1:0] is ignored.
- Grant (combinational per lane): gnt = req & ~stall & (cnt < FIFO_DEPTH) & ~rst_i.
  - A transaction is accepted on a cycle with req & gnt.
- Per-lane outstanding counter cnt, width log2(FIFO_DEPTH+1):
  - +1 on accept, -1 on pop (r_valid & r_ready).
  - Accept and pop in the same cycle: cnt unchanged.
  - cnt never exceeds FIFO_DEPTH, so the FIFO cannot overflow.
- Memory access happens at the accept edge:
  - Write: bytes with be[k] = 1 are updated; others are held.
  - Read: captures the pre-edge word.
  - Same-lane ordering is program order.
  - Cross-lane writes to the same word in the same cycle: highest lane index wins per byte.
  - A read and a write to the same word in the same cycle on different lanes: the read returns the old data.
- Response path:
  - On accept, {rdata or 0, id} enters stage 1 of a LAT-stage valid/data shift pipeline.
  - The pipeline advances unconditionally every cycle.
  - At stage LAT the entry pushes into the lane FIFO (depth FIFO_DEPTH).
  - r_valid = FIFO not empty; r_data/r_id = FIFO head.
  - Accept at edge t gives earliest r_valid in the cycle after edge t+LAT-1, i.e. LAT cycles after the accept cycle.
  - Push and pop on the same cycle are both allowed.
  - r_valid/r_data/r_id hold stable while r_ready = 0.
  - Responses are returned strictly in accept order per lane.
- Lanes are fully independent except for the shared memory array.
- busy_o = OR over lanes of (cnt != 0).

Test Plan:
- Single read: preload word 0x10 = 0xDEADBEEF via lane0 write (be=4'hF, addr 0x40). Then lane0 read addr 0x40, id 0x5A, r_ready = 1 → r_valid exactly LAT cycles after accept, r_data = 0xDEADBEEF, r_id = 0x5A. The write response has r_data = 0.
- Byte enables: write 0x11223344 be=4'b0101 over 0xFFFFFFFF at addr 0x80 → read returns 0xFF22FF44.
- Backpressure/credit: FIFO_DEPTH = 4, lane1 r_ready = 0, continuous read req → exactly 4 grants, then gnt = 0. Raising r_ready → 4 in-order responses, gnt reasserts the cycle after the first pop; cnt never exceeds 4.
- Cross-lane conflict: same cycle lane0 writes 0xAAAAAAAA and lane3 writes 0x55555555 to addr 0x100, lane2 reads 0x100 (old 0x0) → lane2 gets 0x0; a subsequent read gets 0x55555555.
- Stall and wrap: stall_i[2] = 1 with req → no gnt, cnt = 0. With MEM_WORDS = 4096, a write to 0x4000 followed by a read of 0x0000 returns the written value.
- Reset mid-flight: 3 reads outstanding on lane0 and rst_i pulsed 1 cycle → r_valid = 0 and busy_o = 0 the cycle after. No stale responses afterwards; memory data is preserved on re-read.

Source files
------------

// File: rtl/sfm_tcdm_responder.sv
// sfm_tcdm_responder: multi-lane TCDM slave memory with fixed-latency, in-order, backpressured responses
module sfm_tcdm_responder #(
   parameter int MP         = 4,
   parameter int MEM_WORDS  = 4096,
   parameter int LAT        = 2,
   parameter int FIFO_DEPTH = 4,
   parameter int IW         = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [MP-1:0]         tcdm_req_i,
   output logic [MP-1:0]         tcdm_gnt_o,
   input  logic [MP-1:0][31:0]   tcdm_add_i,
   input  logic [MP-1:0]         tcdm_wen_i,
   input  logic [MP-1:0][3:0]    tcdm_be_i,
   input  logic [MP-1:0][31:0]   tcdm_data_i,
   input  logic [MP-1:0][IW-1:0] tcdm_id_i,
   input  logic [MP-1:0]         tcdm_r_ready_i,
   output logic [MP-1:0]         tcdm_r_valid_o,
   output logic [MP-1:0][31:0]   tcdm_r_data_o,
   output logic [MP-1:0][IW-1:0] tcdm_r_id_o,
   input  logic [MP-1:0]         stall_i,
   output logic                  busy_o
);
   localparam int AW = $clog2(MEM_WORDS);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int PW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
   localparam int EW = 32 + IW;
   logic [31:0]          r_mem [MEM_WORDS];
   logic [MP-1:0]        w_acc;
   logic [MP-1:0]        w_busy;
   logic [MP-1:0][AW-1:0] w_idx;
   // later lanes overwrite earlier ones, so the highest lane wins per byte
   always_ff @(posedge clk_i)
      for (int l = 0; l < MP; l++)
         for (int k = 0; k < 4; k++)
            if (w_acc[l] && !tcdm_wen_i[l] && tcdm_be_i[l][k])
               r_mem[w_idx[l]][8*k +: 8] <= tcdm_data_i[l][8*k +: 8];
   assign busy_o = |w_busy & ~rst_i;
   for (genvar l = 0; l < MP; l++) begin : g_lane
      logic [CW-1:0] r_cnt;
      logic [CW-1:0] r_fill;
      logic [PW-1:0] r_wp;
      logic [PW-1:0] r_rp;
      logic [EW-1:0] r_fifo [FIFO_DEPTH];
      logic          w_push;
      logic          w_pop;
      logic          w_valid;
      logic [EW-1:0] w_ent;
      logic [EW-1:0] w_pent;
      logic          w_unused_add;
      assign w_unused_add   = ^{tcdm_add_i[l][31:AW+2], tcdm_add_i[l][1:0]};
      assign w_idx[l]       = tcdm_add_i[l][AW+1:2];
      assign tcdm_gnt_o[l]  = tcdm_req_i[l] & ~stall_i[l] & (r_cnt < CW'(FIFO_DEPTH)) & ~rst_i;
      assign w_acc[l]       = tcdm_req_i[l] & tcdm_gnt_o[l];
      assign w_ent          = {tcdm_wen_i[l] ? r_mem[w_idx[l]] : 32'h0, tcdm_id_i[l]};
      assign w_valid        = (r_fill != '0) & ~rst_i;
      assign w_pop          = w_valid & tcdm_r_ready_i[l];
      assign w_busy[l]      = r_cnt != '0;
      assign tcdm_r_valid_o[l] = w_valid;
      assign {tcdm_r_data_o[l], tcdm_r_id_o[l]} = w_valid ? r_fifo[r_rp] : '0;
      // the FIFO write itself is the last latency stage
      if (LAT == 1) begin : g_nopipe
         assign w_push = w_acc[l];
         assign w_pent = w_ent;
      end else begin : g_pipe
         logic [LAT-2:0] r_pv;
         logic [EW-1:0]  r_pd [LAT-1];
         always_ff @(posedge clk_i) begin
            r_pd[0] <= w_ent;
            for (int i = 1; i < LAT - 1; i++) r_pd[i] <= r_pd[i-1];
            if (rst_i) r_pv <= '0;
            else r_pv <= (LAT-1)'({r_pv, w_acc[l]});
         end
         assign w_push = r_pv[LAT-2];
         assign w_pent = r_pd[LAT-2];
      end
      always_ff @(posedge clk_i) begin
         if (w_push) r_fifo[r_wp] <= w_pent;
         if (rst_i) begin
            r_wp   <= '0;
            r_rp   <= '0;
            r_fill <= '0;
            r_cnt  <= '0;
         end else begin
            if (w_push) r_wp <= r_wp == PW'(FIFO_DEPTH - 1) ? '0 : r_wp + PW'(1);
            if (w_pop) r_rp <= r_rp == PW'(FIFO_DEPTH - 1) ? '0 : r_rp + PW'(1);
            r_fill <= r_fill + CW'(w_push) - CW'(w_pop);
            r_cnt  <= r_cnt + CW'(w_acc[l]) - CW'(w_pop);
         end
      end
   end
endmodule
